// File: rtl/sram_pkg.sv
// Shared definitions for the result-SRAM access path.
// Combinational only: constants and type definitions.
// Backpressure: not applicable.
package sram_pkg;

  localparam int A_WIDTH = 7;
  localparam int D_WIDTH = 32;

  // SRAM RW pin encoding
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Requester identifiers, also the encoding of the last-grant register
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester A/B handshakes, clear handshake and the SRAM pin set.
// Latency: wires only.
// Backpressure: Req held by a requester until its Ack pulse.
interface sram_arbiter_if #(
  parameter int A_WIDTH = sram_pkg::A_WIDTH,
  parameter int D_WIDTH = sram_pkg::D_WIDTH
);

  logic               A_Req;
  logic               A_RW;
  logic [A_WIDTH-1:0] A_Addr;
  logic [D_WIDTH-1:0] A_Wdata;
  logic               A_Ack;
  logic               A_Rvalid;
  logic [D_WIDTH-1:0] A_Rdata;

  logic               B_Req;
  logic               B_RW;
  logic [A_WIDTH-1:0] B_Addr;
  logic [D_WIDTH-1:0] B_Wdata;
  logic               B_Ack;
  logic               B_Rvalid;
  logic [D_WIDTH-1:0] B_Rdata;

  logic               Clr_Req;
  logic               Clr_Done;

  logic               Sram_En;
  logic               Sram_RW;
  logic [A_WIDTH-1:0] Sram_Addr;
  logic [D_WIDTH-1:0] Sram_Din;
  logic               Sram_Rst;
  logic [D_WIDTH-1:0] Sram_Dout;

  // Arbiter side: takes requests and SRAM read data, drives acks and SRAM pins
  modport slave (
    input  A_Req, A_RW, A_Addr, A_Wdata,
    input  B_Req, B_RW, B_Addr, B_Wdata,
    input  Clr_Req, Sram_Dout,
    output A_Ack, A_Rvalid, A_Rdata,
    output B_Ack, B_Rvalid, B_Rdata,
    output Clr_Done, Sram_En, Sram_RW, Sram_Addr, Sram_Din, Sram_Rst
  );

  // Environment side: requesters plus the SRAM macro
  modport master (
    output A_Req, A_RW, A_Addr, A_Wdata,
    output B_Req, B_RW, B_Addr, B_Wdata,
    output Clr_Req, Sram_Dout,
    input  A_Ack, A_Rvalid, A_Rdata,
    input  B_Ack, B_Rvalid, B_Rdata,
    input  Clr_Done, Sram_En, Sram_RW, Sram_Addr, Sram_Din, Sram_Rst
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arb2
  import sram_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);

  // At most one grant is ever high; on a tie the previous loser wins
  always_comb begin
    grant_a = a_req & (~b_req | (last_grant == REQ_B));
    grant_b = b_req & (~a_req | (last_grant == REQ_A));
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin controller serialising requesters A/B and whole-memory clears onto one SRAM port.
// Latency: Ack 1 cycle after the Req is sampled; read data/Rvalid 3 cycles after.
// Backpressure: Req is held until Ack; a held Clr_Req starves both requesters.
module sram_arbiter
  import sram_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst,
  sram_arbiter_if.slave bus
);

  state_t state;
  logic   last_grant;   // also identifies the owner of the access in flight
  logic   grant_a;
  logic   grant_b;

  rr_arb2 u_rr_arb2 (
    .a_req      (bus.A_Req),
    .b_req      (bus.B_Req),
    .last_grant (last_grant),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  // Control FSM: every output is a register, pulses default low each cycle
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      last_grant   <= REQ_B;
      bus.A_Ack    <= 1'b0;
      bus.A_Rvalid <= 1'b0;
      bus.A_Rdata  <= '0;
      bus.B_Ack    <= 1'b0;
      bus.B_Rvalid <= 1'b0;
      bus.B_Rdata  <= '0;
      bus.Clr_Done <= 1'b0;
      bus.Sram_En  <= 1'b0;
      bus.Sram_RW  <= 1'b0;
      bus.Sram_Addr <= '0;
      bus.Sram_Din <= '0;
      bus.Sram_Rst <= 1'b0;
    end else begin
      bus.A_Ack    <= 1'b0;
      bus.A_Rvalid <= 1'b0;
      bus.B_Ack    <= 1'b0;
      bus.B_Rvalid <= 1'b0;
      bus.Clr_Done <= 1'b0;
      bus.Sram_En  <= 1'b0;
      bus.Sram_Rst <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Clr_Req) begin
            // Clear outranks both requesters; Clr_Done rides with Sram_Rst
            bus.Sram_Rst <= 1'b1;
            bus.Clr_Done <= 1'b1;
            state        <= CLEAR;
          end else if (grant_a) begin
            bus.Sram_RW   <= bus.A_RW;
            bus.Sram_Addr <= bus.A_Addr;
            bus.Sram_Din  <= bus.A_Wdata;
            bus.Sram_En   <= 1'b1;
            bus.A_Ack     <= 1'b1;
            last_grant    <= REQ_A;
            state         <= ISSUE;
          end else if (grant_b) begin
            bus.Sram_RW   <= bus.B_RW;
            bus.Sram_Addr <= bus.B_Addr;
            bus.Sram_Din  <= bus.B_Wdata;
            bus.Sram_En   <= 1'b1;
            bus.B_Ack     <= 1'b1;
            last_grant    <= REQ_B;
            state         <= ISSUE;
          end
        end

        CLEAR: begin
          state <= IDLE;
        end

        ISSUE: begin
          // The SRAM samples the access at the end of this cycle
          state <= (bus.Sram_RW == RW_READ) ? RESP : IDLE;
        end

        RESP: begin
          // Sram_Dout is valid now; hand it to whoever owns the access
          if (last_grant == REQ_A) begin
            bus.A_Rdata  <= bus.Sram_Dout;
            bus.A_Rvalid <= 1'b1;
          end else begin
            bus.B_Rdata  <= bus.Sram_Dout;
            bus.B_Rvalid <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import sram_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  sram_arbiter_if bus ();

  sram_arbiter dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // Behavioural 128x32 SRAM: sync clear, 1-cycle read, Data_Out zero unless the prior cycle read
  logic [31:0] mem [128];
  always @(posedge Clk) begin
    bus.Sram_Dout <= '0;
    if (bus.Sram_Rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (bus.Sram_En) begin
      if (bus.Sram_RW) mem[bus.Sram_Addr] <= bus.Sram_Din;
      else             bus.Sram_Dout <= mem[bus.Sram_Addr];
    end
  end

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    bus.A_Req = 1'b0; bus.A_RW = 1'b0; bus.A_Addr = '0; bus.A_Wdata = '0;
    bus.B_Req = 1'b0; bus.B_RW = 1'b0; bus.B_Addr = '0; bus.B_Wdata = '0;
    bus.Clr_Req = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0]  pulses;
    logic [39:0] sbus;
    Rst = 1'b1;
    idle_inputs();
    repeat (2) cyc();
    pulses = {bus.A_Ack, bus.B_Ack, bus.A_Rvalid, bus.B_Rvalid, bus.Clr_Done, bus.Sram_En, bus.Sram_Rst};
    sbus   = {bus.Sram_RW, bus.Sram_Addr, bus.Sram_Din};
    checks++; if (pulses !== 7'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000000", pulses); end
    checks++; if (sbus !== 40'b0) begin errors++; $display("FAIL reset_sram_bus: got %h want 0", sbus); end
    checks++; if ({bus.A_Rdata, bus.B_Rdata} !== 64'b0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.A_Rdata, bus.B_Rdata); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    checks++; if (dut.last_grant !== REQ_B) begin errors++; $display("FAIL reset_last_grant: got %b want %b", dut.last_grant, REQ_B); end
    Rst = 1'b0;
    cyc();
  endtask

  // Both sides write continuously; A must win first after reset, then strict alternation
  task automatic test_round_robin();
    logic exp_a, exp_b;
    bus.A_Req = 1'b1; bus.A_RW = 1'b1; bus.A_Addr = 7'd1; bus.A_Wdata = 32'h1111_1111;
    bus.B_Req = 1'b1; bus.B_RW = 1'b1; bus.B_Addr = 7'd2; bus.B_Wdata = 32'h2222_2222;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      exp_a = (c == 1) || (c == 5);
      exp_b = (c == 3) || (c == 7);
      checks++;
      if ({bus.A_Ack, bus.B_Ack} !== {exp_a, exp_b}) begin
        errors++; $display("FAIL rr_acks cycle %0d: got A=%b B=%b want A=%b B=%b", c, bus.A_Ack, bus.B_Ack, exp_a, exp_b);
      end
      if (exp_b) begin
        checks++;
        if (bus.Sram_Addr !== 7'd2) begin errors++; $display("FAIL rr_b_addr cycle %0d: got %0d want 2", c, bus.Sram_Addr); end
      end
    end
    idle_inputs();
    cyc();
    checks++; if (mem[1] !== 32'h1111_1111) begin errors++; $display("FAIL rr_mem1: got %h want 11111111", mem[1]); end
    checks++; if (mem[2] !== 32'h2222_2222) begin errors++; $display("FAIL rr_mem2: got %h want 22222222", mem[2]); end
  endtask

  task automatic test_write_a();
    logic [39:0] sbus;
    bus.A_Req = 1'b1; bus.A_RW = 1'b1; bus.A_Addr = 7'd5; bus.A_Wdata = 32'hDEAD_BEEF;
    cyc();
    sbus = {bus.Sram_RW, bus.Sram_Addr, bus.Sram_Din};
    checks++; if (bus.A_Ack !== 1'b1) begin errors++; $display("FAIL wr_a_ack: got %b want 1", bus.A_Ack); end
    checks++; if (bus.B_Ack !== 1'b0) begin errors++; $display("FAIL wr_b_ack: got %b want 0", bus.B_Ack); end
    checks++; if (bus.Sram_En !== 1'b1) begin errors++; $display("FAIL wr_en: got %b want 1", bus.Sram_En); end
    checks++; if (sbus !== {1'b1, 7'd5, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_sram_bus: got %h want 05deadbeef|rw", sbus); end
    bus.A_Req = 1'b0;
    cyc();
    checks++; if ({bus.A_Ack, bus.Sram_En} !== 2'b00) begin errors++; $display("FAIL wr_pulse_end: got ack=%b en=%b want 0 0", bus.A_Ack, bus.Sram_En); end
    checks++; if (mem[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_mem5: got %h want deadbeef", mem[5]); end
  endtask

  task automatic test_read_a();
    bus.A_Req = 1'b1; bus.A_RW = 1'b0; bus.A_Addr = 7'd5;
    cyc();
    checks++; if ({bus.A_Ack, bus.Sram_En, bus.Sram_RW} !== 3'b110) begin errors++; $display("FAIL rd_issue: got ack/en/rw=%b%b%b want 110", bus.A_Ack, bus.Sram_En, bus.Sram_RW); end
    bus.A_Req = 1'b0;
    cyc();
    checks++; if (bus.A_Rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_c2: got %b want 0", bus.A_Rvalid); end
    cyc();
    checks++; if (bus.A_Rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid_c3: got %b want 1", bus.A_Rvalid); end
    checks++; if (bus.A_Rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata_c3: got %h want deadbeef", bus.A_Rdata); end
    checks++; if (bus.B_Rvalid !== 1'b0) begin errors++; $display("FAIL rd_b_rvalid: got %b want 0", bus.B_Rvalid); end
    cyc();
    checks++; if (bus.A_Rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_c4: got %b want 0", bus.A_Rvalid); end
    checks++; if (bus.A_Rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata_hold: got %h want deadbeef", bus.A_Rdata); end
  endtask

  // Clear outranks a simultaneous A read; the read then sees the cleared word
  task automatic test_clear();
    bus.Clr_Req = 1'b1;
    bus.A_Req = 1'b1; bus.A_RW = 1'b0; bus.A_Addr = 7'd5;
    cyc();
    checks++; if ({bus.Sram_Rst, bus.Clr_Done} !== 2'b11) begin errors++; $display("FAIL clr_pulse: got rst=%b done=%b want 1 1", bus.Sram_Rst, bus.Clr_Done); end
    checks++; if ({bus.A_Ack, bus.Sram_En} !== 2'b00) begin errors++; $display("FAIL clr_no_access: got ack=%b en=%b want 0 0", bus.A_Ack, bus.Sram_En); end
    bus.Clr_Req = 1'b0;
    cyc();
    checks++; if ({bus.Sram_Rst, bus.Clr_Done, bus.A_Ack} !== 3'b000) begin errors++; $display("FAIL clr_one_cycle: got rst/done/ack=%b%b%b want 000", bus.Sram_Rst, bus.Clr_Done, bus.A_Ack); end
    checks++; if (mem[1] !== 32'h0) begin errors++; $display("FAIL clr_mem1: got %h want 0", mem[1]); end
    cyc();
    checks++; if (bus.A_Ack !== 1'b1) begin errors++; $display("FAIL clr_then_a_ack: got %b want 1", bus.A_Ack); end
    bus.A_Req = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.A_Rvalid !== 1'b1) begin errors++; $display("FAIL clr_rvalid: got %b want 1", bus.A_Rvalid); end
    checks++; if (bus.A_Rdata !== 32'h0) begin errors++; $display("FAIL clr_rdata: got %h want 00000000", bus.A_Rdata); end
  endtask

  // Reset during a B read's ISSUE cycle must drop it entirely
  task automatic test_rst_mid();
    logic [6:0] pulses;
    logic       saw_b_rvalid;
    bus.B_Req = 1'b1; bus.B_RW = 1'b1; bus.B_Addr = 7'd2; bus.B_Wdata = 32'h2222_2222;
    cyc();
    checks++; if (bus.B_Ack !== 1'b1) begin errors++; $display("FAIL rst_prep_b_ack: got %b want 1", bus.B_Ack); end
    bus.B_Req = 1'b0;
    cyc();
    bus.B_Req = 1'b1; bus.B_RW = 1'b0; bus.B_Addr = 7'd2;
    cyc();
    checks++; if (bus.B_Ack !== 1'b1) begin errors++; $display("FAIL rst_issue_b_ack: got %b want 1", bus.B_Ack); end
    Rst = 1'b1;
    bus.B_Req = 1'b0;
    #1;
    pulses = {bus.A_Ack, bus.B_Ack, bus.A_Rvalid, bus.B_Rvalid, bus.Clr_Done, bus.Sram_En, bus.Sram_Rst};
    checks++; if (pulses !== 7'b0) begin errors++; $display("FAIL rst_mid_pulses: got %b want 0000000", pulses); end
    checks++; if ({bus.Sram_RW, bus.Sram_Addr, bus.Sram_Din, bus.A_Rdata, bus.B_Rdata} !== 104'b0) begin errors++; $display("FAIL rst_mid_data: addr=%0d din=%h brdata=%h want 0", bus.Sram_Addr, bus.Sram_Din, bus.B_Rdata); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_mid_state: got %0d want %0d", dut.state, IDLE); end
    cyc();
    Rst = 1'b0;
    saw_b_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (bus.B_Rvalid !== 1'b0) saw_b_rvalid = 1'b1;
    end
    checks++; if (saw_b_rvalid !== 1'b0) begin errors++; $display("FAIL rst_b_rvalid_seen: got %b want 0", saw_b_rvalid); end
    bus.A_Req = 1'b1; bus.A_RW = 1'b0; bus.A_Addr = 7'd2;
    cyc();
    checks++; if (bus.A_Ack !== 1'b1) begin errors++; $display("FAIL rst_after_a_ack: got %b want 1", bus.A_Ack); end
    bus.A_Req = 1'b0;
    cyc();
    cyc();
    checks++; if ({bus.A_Rvalid, bus.A_Rdata} !== {1'b1, 32'h2222_2222}) begin errors++; $display("FAIL rst_after_a_read: got v=%b d=%h want 1 22222222", bus.A_Rvalid, bus.A_Rdata); end
    cyc();
  endtask

  task automatic test_wrap();
    bus.B_Req = 1'b1; bus.B_RW = 1'b1; bus.B_Addr = 7'd127; bus.B_Wdata = 32'h1234_5678;
    cyc();
    checks++; if ({bus.B_Ack, bus.Sram_Addr} !== {1'b1, 7'd127}) begin errors++; $display("FAIL wrap_wr: got ack=%b addr=%0d want 1 127", bus.B_Ack, bus.Sram_Addr); end
    bus.B_Req = 1'b0;
    cyc();
    bus.B_Req = 1'b1; bus.B_RW = 1'b0; bus.B_Addr = 7'd127;
    cyc();
    checks++; if (bus.B_Ack !== 1'b1) begin errors++; $display("FAIL wrap_rd_ack: got %b want 1", bus.B_Ack); end
    bus.B_Req = 1'b0;
    cyc();
    cyc();
    checks++; if ({bus.B_Rvalid, bus.B_Rdata} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL wrap_rd: got v=%b d=%h want 1 12345678", bus.B_Rvalid, bus.B_Rdata); end
    checks++; if ({bus.A_Rvalid, bus.A_Rdata} !== {1'b0, 32'h2222_2222}) begin errors++; $display("FAIL wrap_a_untouched: got v=%b d=%h want 0 22222222", bus.A_Rvalid, bus.A_Rdata); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_a();
    test_read_a();
    test_clear();
    test_rst_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester round-robin controller in front of the single-port 128x32 result SRAM (synchronous 1-cycle read; Data_Out is zero in any cycle that does not follow a read).
- Serialises requester A and requester B accesses onto the SRAM port with a Req/Ack handshake.
- Returns read data with a one-cycle valid pulse.
- Sequences a whole-memory clear on request.

Parameters:
- A_WIDTH, 7, SRAM address width.
- D_WIDTH, 32, SRAM data width.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- A_Req  in  1  requester A access request; held until A_Ack.
- A_RW  in  1  1 = write, 0 = read; valid while A_Req.
- A_Addr  in  A_WIDTH  A access address.
- A_Wdata  in  D_WIDTH  A write data.
- A_Ack  out  1  one-cycle pulse: A request accepted.
- A_Rvalid  out  1  one-cycle pulse: A_Rdata valid.
- A_Rdata  out  D_WIDTH  read data returned to A.
- B_Req, B_RW, B_Addr, B_Wdata, B_Ack, B_Rvalid, B_Rdata: same as the A ports, for requester B.
- Clr_Req  in  1  request to clear the entire SRAM.
- Clr_Done  out  1  one-cycle pulse: clear issued.
- Sram_En  out  1  to SRAM En.
- Sram_RW  out  1  to SRAM RW.
- Sram_Addr  out  A_WIDTH  to SRAM Addr.
- Sram_Din  out  D_WIDTH  to SRAM Data_In.
- Sram_Rst  out  1  to SRAM Rst (synchronous clear).
- Sram_Dout  in  D_WIDTH  from SRAM Data_Out.

Behaviour:
- All outputs are registered. On Rst every output resets to 0, state resets to IDLE, and Last_Grant resets to B, so A wins the first tie.
- States: IDLE, CLEAR, ISSUE, RESP.
- IDLE, arbitration priority:
  - Clr_Req wins over both requesters → CLEAR. Sram_Rst = 1 for that cycle; Clr_Done pulses in the same cycle.
  - Otherwise, if only one requester's Req is high, it wins.
  - If both are high, the requester that is not Last_Grant wins.
  - On a win: latch RW/Addr/Wdata into the Sram_* registers; set Last_Grant; go to ISSUE.
- ISSUE:
  - Sram_En = 1 and the winner's Ack = 1, both for exactly this cycle.
  - Write → next state IDLE.
  - Read → next state RESP.
- RESP:
  - Sram_Dout is valid in this cycle.
  - At the closing edge, capture it into the owner's Rdata and raise the owner's Rvalid for the following cycle; next state IDLE.
- CLEAR → IDLE after one cycle.
- Latency from a Req sampled in IDLE at cycle 0:
  - Ack in cycle 1.
  - Write lands in the SRAM at the end of cycle 1.
  - Read: Rvalid/Rdata in cycle 3.
  - Next arbitration: cycle 2 after a write, cycle 3 after a read.
- Requesters must drop Req, or present a new request, on the edge after Ack. A Req still high in IDLE is a new request.
- Rdata holds its value until the next read for the same requester. Rvalid is high for only one cycle.
- Sram_En, Sram_Rst, the Acks, Rvalids and Clr_Done are 0 in every cycle not listed above.
- Sram_Addr, Sram_Din and Sram_RW hold their last values when idle; the SRAM ignores them with En = 0.
- Clr_Req held high means one clear per IDLE visit; requesters are starved while it stays high. This is intentional.
- Asynchronous Rst mid-ISSUE or mid-RESP drops the in-flight access: no Ack, no Rvalid, no partial Rdata update.
- Req with an out-of-range address cannot occur: address widths are equal on both sides.

Decomposition:
- Shared package sram_pkg:
  - A_WIDTH and D_WIDTH defaults.
  - RW encoding constants RW_READ = 0, RW_WRITE = 1.
  - State encoding: IDLE, CLEAR, ISSUE, RESP.
  - Requester ID constants REQ_A = 0, REQ_B = 1.
- Sub-module rr_arb2: combinational 2-way round-robin pick from A_Req, B_Req and Last_Grant, producing grant_a/grant_b. Reused by future multi-client SRAM blocks.

Test Plan:
- Reset then A write Addr=5, Data=0xDEADBEEF → A_Ack in cycle 1; Sram_En=1, Sram_RW=1, Sram_Addr=5 in cycle 1; no B_Ack.
- A read Addr=5 after that write → A_Rvalid in cycle 3 with A_Rdata=0xDEADBEEF; A_Rvalid low in cycles 2 and 4.
- A and B both request continuously (A writes Addr 1, B writes Addr 2) → grant order A, B, A, B; each Ack one cycle; no back-to-back Ack to the same side.
- Clr_Req asserted together with A_Req → Sram_Rst=1 and Clr_Done=1 for one cycle, then A is served. A read of Addr=5 then returns 0x00000000.
- Rst asserted in the ISSUE cycle of a B read of Addr=2 → all outputs 0 immediately, B_Rvalid never asserts, state IDLE; a new A request is served normally.
- B read of Addr=127 (wrap boundary) after writing 0x12345678 there → B_Rdata=0x12345678 in cycle 3; A_Rdata unchanged.
